// File: rtl/sdram_port_arb.sv
// sdram_port_arb: shares one toggle-handshake SDRAM controller port between
// three requesters (download writer, hiscore/NVRAM engine, CPU work-RAM).
// Round-robin arbitration with optional strict priority for requester 0,
// one outstanding transaction, latched command fields and a sticky watchdog.
module sdram_port_arb #(
    parameter int AW      = 23,
    parameter int PRIO0   = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_a,
    input  logic [1:0]    r0_ds,
    input  logic [15:0]   r0_d,
    output logic          r0_ack,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_a,
    input  logic [1:0]    r1_ds,
    input  logic [15:0]   r1_d,
    output logic          r1_ack,
    input  logic          r2_req,
    input  logic          r2_we,
    input  logic [AW-1:0] r2_a,
    input  logic [1:0]    r2_ds,
    input  logic [15:0]   r2_d,
    output logic          r2_ack,
    output logic [15:0]   q,
    output logic          port_req,
    input  logic          port_ack,
    output logic          port_we,
    output logic [AW-1:0] port_a,
    output logic [1:0]    port_ds,
    output logic [15:0]   port_d,
    input  logic [15:0]   port_q,
    output logic          busy,
    output logic [1:0]    grant,
    output logic          err
);

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q;
    logic [2:0]      ack_q;
    logic [1:0]      grant_q;
    logic            err_q;
    logic [WDW-1:0]  wd_q;
    logic [WDW-1:0]  wdInc_d;
    logic [15:0]     rdata_q;
    logic            preq_q;
    logic            we_q;
    logic [AW-1:0]   a_q;
    logic [1:0]      ds_q;
    logic [15:0]     d_q;

    logic [2:0]      reqVec;
    logic [1:0]      c0, c1, c2;
    logic [1:0]      win_d;
    logic            winValid_d;
    logic            selWe_d;
    logic [AW-1:0]   selA_d;
    logic [1:0]      selDs_d;
    logic [15:0]     selD_d;

    assign reqVec = {r2_req, r1_req, r0_req};

    // Winner: requester 0 first when prioritised, else first pending after the last grant.
    always_comb begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
        case (grant_q)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        winValid_d = |reqVec;
        if ((PRIO0 != 0) && r0_req) begin
            win_d = 2'd0;
        end else if (reqVec[c0]) begin
            win_d = c0;
        end else if (reqVec[c1]) begin
            win_d = c1;
        end else begin
            win_d = c2;
        end
    end

    // Command fields of the winning requester, ready to be latched on the grant edge.
    always_comb begin
        selWe_d = r2_we;
        selA_d  = r2_a;
        selDs_d = r2_ds;
        selD_d  = r2_d;
        case (win_d)
            2'd0:    begin selWe_d = r0_we; selA_d = r0_a; selDs_d = r0_ds; selD_d = r0_d; end
            2'd1:    begin selWe_d = r1_we; selA_d = r1_a; selDs_d = r1_ds; selD_d = r1_d; end
            default: begin selWe_d = r2_we; selA_d = r2_a; selDs_d = r2_ds; selD_d = r2_d; end
        endcase
    end

    assign wdInc_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

    // Arbitration FSM: grant in IDLE, wait for the toggle ack, one DONE cycle to let req drop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            preq_q  <= port_ack;
            ack_q   <= '0;
            grant_q <= 2'd2;
            err_q   <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            a_q     <= '0;
            ds_q    <= '0;
            d_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winValid_d) begin
                        we_q    <= selWe_d;
                        a_q     <= selA_d;
                        ds_q    <= selDs_d;
                        d_q     <= selD_d;
                        grant_q <= win_d;
                        preq_q  <= ~preq_q;
                        wd_q    <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (port_ack == preq_q) begin
                        if (!we_q) begin
                            rdata_q <= port_q;
                        end
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        wd_q <= wdInc_d;
                        if (wdInc_d == WD_MAX) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r0_ack   = ack_q[0];
    assign r1_ack   = ack_q[1];
    assign r2_ack   = ack_q[2];
    assign q        = rdata_q;
    assign port_req = preq_q;
    assign port_we  = we_q;
    assign port_a   = a_q;
    assign port_ds  = ds_q;
    assign port_d   = d_q;
    assign busy     = (state_q != IDLE);
    assign grant    = grant_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: two arbiter instances (round-robin and requester-0
// priority) driven by requester and controller models, with a
// transaction-level reference model of grants, acks and read data.
module tb_sdram_port_arb;

    localparam int AW  = 23;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset_n;

    logic [2:0]    req [2];
    logic [2:0]    we  [2];
    logic [AW-1:0] ra  [2][3];
    logic [1:0]    rds [2][3];
    logic [15:0]   rd  [2][3];
    logic          ack0 [2];
    logic          ack1 [2];
    logic          ack2 [2];
    logic [15:0]   qv    [2];
    logic          preq  [2];
    logic          pack  [2];
    logic          pwe   [2];
    logic [AW-1:0] pa    [2];
    logic [1:0]    pds   [2];
    logic [15:0]   pd    [2];
    logic [15:0]   pq    [2];
    logic          busyv [2];
    logic [1:0]    grantv[2];
    logic          errv  [2];

    // Instance 0 is pure round-robin, instance 1 gives requester 0 strict priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdram_port_arb #(.AW(AW), .PRIO0(g), .TIMEOUT(TMO)) dut (
            .clk(clk), .reset_n(reset_n),
            .r0_req(req[g][0]), .r0_we(we[g][0]), .r0_a(ra[g][0]), .r0_ds(rds[g][0]), .r0_d(rd[g][0]), .r0_ack(ack0[g]),
            .r1_req(req[g][1]), .r1_we(we[g][1]), .r1_a(ra[g][1]), .r1_ds(rds[g][1]), .r1_d(rd[g][1]), .r1_ack(ack1[g]),
            .r2_req(req[g][2]), .r2_we(we[g][2]), .r2_a(ra[g][2]), .r2_ds(rds[g][2]), .r2_d(rd[g][2]), .r2_ack(ack2[g]),
            .q(qv[g]), .port_req(preq[g]), .port_ack(pack[g]), .port_we(pwe[g]), .port_a(pa[g]),
            .port_ds(pds[g]), .port_d(pd[g]), .port_q(pq[g]), .busy(busyv[g]), .grant(grantv[g]), .err(errv[g])
        );
    end

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            mLast [2];
    bit            mBusy [2];
    bit            mDone [2];
    bit            mPend [2];
    int            mWin  [2];
    int            mWait [2];
    bit            mErr  [2];
    logic [15:0]   mQ    [2];
    logic [15:0]   mPqVal[2];
    logic          mPreq [2];
    logic          mWe   [2];
    logic [AW-1:0] mA    [2];
    logic [1:0]    mDs   [2];
    logic [15:0]   mD    [2];

    bit          active [3];
    int          gap    [3];
    int          rc     [3];
    int          ackCount[3];
    int          dMin = 1;
    int          dMax = 4;
    bit          ackEn = 1'b1;
    bit          forceQ = 1'b0;
    logic [15:0] forceQVal = 16'h0;
    int          cCnt   [2];
    int          cDelay [2];
    int          grantLog[$];

    function automatic int pickWinner(input int last, input logic [2:0] r, input bit prio);
        if (prio && r[0]) return 0;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic setDelay(input int lo, input int hi);
        dMin = lo;
        dMax = hi;
        for (int d = 0; d < 2; d++) cDelay[d] = $urandom_range(lo, hi);
    endtask

    task automatic doReset(input logic ackInit);
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0;
            we[d]  = '0;
            for (int i = 0; i < 3; i++) begin
                ra[d][i] = '0; rds[d][i] = '0; rd[d][i] = '0;
            end
            pack[d] = ackInit; pq[d] = '0;
            mLast[d] = 2; mBusy[d] = 0; mDone[d] = 0; mPend[d] = 0; mWin[d] = 0; mWait[d] = 0;
            mErr[d] = 0; mQ[d] = '0; mPqVal[d] = '0; mPreq[d] = ackInit;
            mWe[d] = 1'b0; mA[d] = '0; mDs[d] = '0; mD[d] = '0;
            cCnt[d] = 0; cDelay[d] = $urandom_range(dMin, dMax);
        end
        for (int i = 0; i < 3; i++) begin rc[i] = 0; ackCount[i] = 0; end
        grantLog.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Runs n clock cycles on instance d: reference model, checks, controller and requester responses.
    task automatic runCycles(input int d, input int n);
        for (int cyc = 0; cyc < n; cyc++) begin
            logic [2:0] rEdge;
            logic [2:0] expAck;
            logic [2:0] ackNow;
            rEdge = req[d];
            @(posedge clk);
            #1;
            expAck = '0;
            if (mDone[d]) begin
                mDone[d] = 0;
            end else if (mBusy[d] && mPend[d]) begin
                expAck[mWin[d]] = 1'b1;
                if (!mWe[d]) mQ[d] = mPqVal[d];
                mBusy[d] = 0; mPend[d] = 0; mDone[d] = 1;
            end else if (mBusy[d]) begin
                if (mWait[d] < TMO) mWait[d]++;
                if (mWait[d] >= TMO) mErr[d] = 1;
            end else if (rEdge != 3'b000) begin
                int w;
                w = pickWinner(mLast[d], rEdge, d == 1);
                mWin[d] = w; mLast[d] = w; mPreq[d] = ~mPreq[d];
                mWe[d] = we[d][w]; mA[d] = ra[d][w]; mDs[d] = rds[d][w]; mD[d] = rd[d][w];
                mBusy[d] = 1; mWait[d] = 0;
                grantLog.push_back(w);
            end
            ackNow = {ack2[d], ack1[d], ack0[d]};

            checks += 10;
            if (preq[d] !== mPreq[d]) begin errors++; $display("[TB] FAIL port_req d%0d c%0d: got %b want %b", d, cyc, preq[d], mPreq[d]); end
            if (pa[d] !== mA[d]) begin errors++; $display("[TB] FAIL port_a d%0d c%0d: got %h want %h", d, cyc, pa[d], mA[d]); end
            if (pwe[d] !== mWe[d]) begin errors++; $display("[TB] FAIL port_we d%0d c%0d: got %b want %b", d, cyc, pwe[d], mWe[d]); end
            if (pds[d] !== mDs[d]) begin errors++; $display("[TB] FAIL port_ds d%0d c%0d: got %b want %b", d, cyc, pds[d], mDs[d]); end
            if (pd[d] !== mD[d]) begin errors++; $display("[TB] FAIL port_d d%0d c%0d: got %h want %h", d, cyc, pd[d], mD[d]); end
            if (ackNow !== expAck) begin errors++; $display("[TB] FAIL acks d%0d c%0d: got %b want %b", d, cyc, ackNow, expAck); end
            if (qv[d] !== mQ[d]) begin errors++; $display("[TB] FAIL q d%0d c%0d: got %h want %h", d, cyc, qv[d], mQ[d]); end
            if (busyv[d] !== (mBusy[d] || mDone[d])) begin errors++; $display("[TB] FAIL busy d%0d c%0d: got %b want %b", d, cyc, busyv[d], mBusy[d] || mDone[d]); end
            if (grantv[d] !== 2'(mLast[d])) begin errors++; $display("[TB] FAIL grant d%0d c%0d: got %0d want %0d", d, cyc, grantv[d], mLast[d]); end
            if (errv[d] !== mErr[d]) begin errors++; $display("[TB] FAIL err d%0d c%0d: got %b want %b", d, cyc, errv[d], mErr[d]); end

            for (int i = 0; i < 3; i++) if (ackNow[i] === 1'b1) ackCount[i]++;

            if (ackEn && (preq[d] !== pack[d])) begin
                cCnt[d]++;
                if (cCnt[d] >= cDelay[d]) begin
                    pq[d] = forceQ ? forceQVal : 16'($urandom);
                    pack[d] = ~pack[d];
                    mPend[d] = 1; mPqVal[d] = pq[d];
                    cCnt[d] = 0; cDelay[d] = $urandom_range(dMin, dMax);
                end
            end

            for (int i = 0; i < 3; i++) begin
                if (ackNow[i] === 1'b1) begin
                    req[d][i] = 1'b0;
                    rc[i] = (gap[i] < 0) ? $urandom_range(0, 3) : gap[i];
                end else if (!req[d][i] && active[i]) begin
                    if (rc[i] > 0) begin
                        rc[i]--;
                    end else begin
                        req[d][i] = 1'b1;
                        we[d][i]  = 1'($urandom_range(0, 1));
                        ra[d][i]  = AW'($urandom);
                        rds[d][i] = 2'($urandom);
                        rd[d][i]  = 16'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin active[i] = 0; gap[i] = 0; end
        ackEn = 1; forceQ = 0;
        setDelay(1, 4);
        doReset(1'b0);
        for (int d = 0; d < 2; d++) begin
            checks += 5;
            if (preq[d] !== 1'b0) begin errors++; $display("[TB] FAIL rst_port_req d%0d: got %b want 0", d, preq[d]); end
            if ({ack2[d], ack1[d], ack0[d], busyv[d], errv[d]} !== 5'b0) begin errors++; $display("[TB] FAIL rst_flags d%0d: got %b want 00000", d, {ack2[d], ack1[d], ack0[d], busyv[d], errv[d]}); end
            if (grantv[d] !== 2'd2) begin errors++; $display("[TB] FAIL rst_grant d%0d: got %0d want 2", d, grantv[d]); end
            if (qv[d] !== 16'h0) begin errors++; $display("[TB] FAIL rst_q d%0d: got %h want 0", d, qv[d]); end
            if ({pwe[d], pa[d], pds[d], pd[d]} !== '0) begin errors++; $display("[TB] FAIL rst_port_fields d%0d: got %h want 0", d, {pwe[d], pa[d], pds[d], pd[d]}); end
        end
    endtask

    task automatic test_single_write();
        setDelay(6, 6);
        req[0][1] = 1'b1; we[0][1] = 1'b1; ra[0][1] = 23'h00123; rds[0][1] = 2'b11; rd[0][1] = 16'hBEEF;
        runCycles(0, 1);
        checks += 3;
        if (preq[0] !== 1'b1) begin errors++; $display("[TB] FAIL wr_port_req: got %b want 1", preq[0]); end
        if (pa[0] !== 23'h00123) begin errors++; $display("[TB] FAIL wr_port_a: got %h want 00123", pa[0]); end
        if (pd[0] !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_port_d: got %h want beef", pd[0]); end
        runCycles(0, 12);
        checks++;
        if (ackCount[1] !== 1) begin errors++; $display("[TB] FAIL wr_ack_cycles: got %0d want 1", ackCount[1]); end
    endtask

    task automatic test_read_return();
        setDelay(3, 3);
        forceQ = 1; forceQVal = 16'h1234;
        req[0][2] = 1'b1; we[0][2] = 1'b0; ra[0][2] = 23'h04000; rds[0][2] = 2'b11; rd[0][2] = 16'h0;
        runCycles(0, 10);
        checks++;
        if (qv[0] !== 16'h1234) begin errors++; $display("[TB] FAIL rd_q: got %h want 1234", qv[0]); end
        forceQ = 0;
        req[0][0] = 1'b1; we[0][0] = 1'b1; ra[0][0] = 23'h00777; rds[0][0] = 2'b01; rd[0][0] = 16'hCAFE;
        runCycles(0, 10);
        checks++;
        if (qv[0] !== 16'h1234) begin errors++; $display("[TB] FAIL rd_q_hold: got %h want 1234", qv[0]); end
    endtask

    task automatic test_round_robin();
        int expSeq[6] = '{0, 1, 2, 0, 1, 2};
        int repeats;
        for (int i = 0; i < 3; i++) begin active[i] = 1; gap[i] = 2; end
        setDelay(1, 4);
        doReset(1'b0);
        runCycles(0, 60);
        checks++;
        if (grantLog.size() < 6) begin
            errors++; $display("[TB] FAIL rr_count: got %0d grants want >=6", grantLog.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (grantLog[k] != expSeq[k]) begin errors++; $display("[TB] FAIL rr_seq[%0d]: got %0d want %0d", k, grantLog[k], expSeq[k]); end
            end
        end
        repeats = 0;
        for (int k = 1; k < grantLog.size(); k++) if (grantLog[k] == grantLog[k-1]) repeats++;
        checks++;
        if (repeats != 0) begin errors++; $display("[TB] FAIL rr_repeat: got %0d want 0", repeats); end
    endtask

    task automatic test_priority();
        int r1Grants;
        active[0] = 1; gap[0] = 0; active[1] = 1; gap[1] = 0; active[2] = 0; gap[2] = 0;
        setDelay(1, 4);
        doReset(1'b0);
        runCycles(1, 40);
        r1Grants = 0;
        foreach (grantLog[k]) if (grantLog[k] == 1) r1Grants++;
        checks++;
        if (r1Grants != 0) begin errors++; $display("[TB] FAIL prio_starve: got %0d r1 grants want 0", r1Grants); end
        active[0] = 0;
        grantLog.delete();
        runCycles(1, 20);
        r1Grants = 0;
        foreach (grantLog[k]) if (grantLog[k] == 1) r1Grants++;
        checks++;
        if (r1Grants == 0) begin errors++; $display("[TB] FAIL prio_release: got 0 r1 grants want >=1"); end
        active[1] = 0;
        runCycles(1, 10);
    endtask

    task automatic test_toggle_resync();
        for (int i = 0; i < 3; i++) begin active[i] = 0; gap[i] = 0; end
        doReset(1'b1);
        checks++;
        if (preq[0] !== 1'b1) begin errors++; $display("[TB] FAIL resync_port_req: got %b want 1", preq[0]); end
        runCycles(0, 4);
        req[0][0] = 1'b1; we[0][0] = 1'b0; ra[0][0] = 23'h00042; rds[0][0] = 2'b10; rd[0][0] = 16'h0;
        runCycles(0, 1);
        checks++;
        if (preq[0] !== 1'b0) begin errors++; $display("[TB] FAIL resync_first_req: got %b want 0", preq[0]); end
        runCycles(0, 8);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) begin active[i] = 0; gap[i] = 0; end
        doReset(1'b0);
        ackEn = 0;
        req[0][2] = 1'b1; we[0][2] = 1'b1; ra[0][2] = 23'h1ABCD; rds[0][2] = 2'b11; rd[0][2] = 16'h5A5A;
        runCycles(0, 12);
        checks += 2;
        if (errv[0] !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err: got %b want 1", errv[0]); end
        if (ackCount[0] + ackCount[1] + ackCount[2] != 0) begin errors++; $display("[TB] FAIL tmo_acks: got %0d want 0", ackCount[0] + ackCount[1] + ackCount[2]); end
        runCycles(0, 5);
        checks++;
        if (errv[0] !== 1'b1) begin errors++; $display("[TB] FAIL tmo_sticky: got %b want 1", errv[0]); end
        ackEn = 1;
        doReset(1'b0);
        checks++;
        if (errv[0] !== 1'b0) begin errors++; $display("[TB] FAIL tmo_clear: got %b want 0", errv[0]); end
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin active[i] = 1; gap[i] = -1; end
            setDelay(1, 7);
            doReset(1'($urandom_range(0, 1)));
            runCycles(d, 300);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_single_write();
        test_read_return();
        test_round_robin();
        test_priority();
        test_toggle_resync();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
